// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs_pkg
//   Definitions shared by the CPU-side memory bridges:
//     state_e : transaction state of a single-outstanding bus bridge
//     size_e  : bus access size encoding (byte / half / word)
// -----------------------------------------------------------------------------
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

endpackage : cpu_defs_pkg

// File: rtl/wen_to_size.sv
// -----------------------------------------------------------------------------
// wen_to_size
//   Combinational encoder from 4-bit byte write strobes to bus access size.
//   Shared by the data-side and instruction-side bridges.
//
//   Ports:
//     wen  in  [3:0] byte write strobes
//     size out size_e encoded access size
//
//   One-hot -> byte, aligned half-word pairs -> half, everything else
//   (full word, zero, or a pattern the core never issues) -> word.
// -----------------------------------------------------------------------------
module wen_to_size
  import cpu_defs_pkg::*;
(
  input  logic [3:0] wen,
  output size_e      size
);

  // NOTE: every path through an always_comb must assign its outputs; the
  // default arm here is what keeps this from inferring a latch.
  always_comb begin
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
  end

endmodule : wen_to_size

// File: rtl/dsram_bridge.sv
// -----------------------------------------------------------------------------
// dsram_bridge
//   Converts the core's single-cycle SRAM-style data port into a split
//   handshake (req / addr_ok / data_ok) bus with one transaction in flight,
//   and produces the data-side pipeline stall.
//
//   Ports:
//     clk, resetn          core clock (rising edge), async active-low reset
//     cpu_en/wen/addr/wdata  MEM-stage access; wen==0 means read
//     cpu_longstall        rest of pipeline frozen; hold the completed access
//     cpu_rdata            load data, held until the pipeline advances
//     cpu_stall            combinational data-side stall
//     bus_req/wr/size/addr/wdata  registered request to the bus
//     bus_addr_ok/data_ok/rdata   bus acceptance, completion and read data
//
//   Build option:
//     DSRAM_BRIDGE_KSEG_MAP_EN  when defined, addresses in kseg0/kseg1
//                               (top bits 2'b10) are unmapped to physical by
//                               clearing the three top bits.
// -----------------------------------------------------------------------------
module dsram_bridge
  import cpu_defs_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_longstall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e              state_q,     state_d;
  logic                bus_req_q,   bus_req_d;
  logic                req_wr_q,    req_wr_d;
  size_e               req_size_q,  req_size_d;
  logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;

  size_e wr_size;

  wen_to_size u_wen_to_size (
    .wen  (cpu_wen),
    .size (wr_size)
  );

  // Next-state and request capture. Read data is only latched for reads so a
  // store leaves the last load value visible on cpu_rdata.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    req_wr_d    = req_wr_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          state_d     = ADDR;
          bus_req_d   = 1'b1;
          req_wr_d    = |cpu_wen;
          req_size_d  = (|cpu_wen) ? wr_size : SIZE_WORD;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          // A slave may accept and complete in the same cycle.
          if (bus_data_ok) begin
            state_d = DONE;
            if (!req_wr_q) rdata_d = bus_rdata;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          state_d = DONE;
          if (!req_wr_q) rdata_d = bus_rdata;
        end
      end
      DONE: begin
        // cpu_en here still belongs to the finished access; only the
        // pipeline advancing (longstall low) frees the bridge.
        if (!cpu_longstall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation and mismatch the synthesized flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      req_wr_q    <= 1'b0;
      req_size_q  <= SIZE_BYTE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      req_wr_q    <= req_wr_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Stall is raised in the same cycle cpu_en appears; gated by resetn so it
  // drops immediately when reset asserts with cpu_en still high.
  assign cpu_stall = resetn & cpu_en & (state_q != DONE);
  assign cpu_rdata = rdata_q;

  assign bus_req   = bus_req_q;
  assign bus_wr    = req_wr_q;
  assign bus_size  = req_size_q;
  assign bus_wdata = req_wdata_q;

`ifdef DSRAM_BRIDGE_KSEG_MAP_EN
  assign bus_addr = (req_addr_q[ADDR_W-1 -: 2] == 2'b10)
                  ? {3'b000, req_addr_q[ADDR_W-4:0]}
                  : req_addr_q;
`else
  assign bus_addr = req_addr_q;
`endif

endmodule : dsram_bridge

// File: tb/tb_dsram_bridge.sv
// -----------------------------------------------------------------------------
// tb_dsram_bridge
//   Directed vectors for dsram_bridge. Each access pushes its expected bus
//   request and expected load data into queues; a monitor pops and compares
//   when the DUT presents an accepted request or completes an access.
// -----------------------------------------------------------------------------
module tb_dsram_bridge;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_longstall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  logic [31:0] last_rd;
  logic        prev_stall;

  dsram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_en        (cpu_en),
    .cpu_wen       (cpu_wen),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_longstall (cpu_longstall),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .bus_req       (bus_req),
    .bus_wr        (bus_wr),
    .bus_size      (bus_size),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_addr_ok   (bus_addr_ok),
    .bus_data_ok   (bus_data_ok),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: accepted requests and completed accesses.
  always @(negedge clk) begin
    if (resetn && bus_req && bus_addr_ok) begin
      if (exp_req.size() == 0) begin
        check("unexpected_bus_req", 32'd1, 32'd0);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        check("bus_wr",   {31'd0, bus_wr},   {31'd0, e.wr});
        check("bus_size", {30'd0, bus_size}, {30'd0, e.size});
        check("bus_addr", bus_addr, e.addr);
        if (e.wr) check("bus_wdata", bus_wdata, e.wdata);
      end
    end
    if (resetn && cpu_en && prev_stall && !cpu_stall) begin
      if (exp_rd.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
      else                    check("cpu_rdata", cpu_rdata, exp_rd.pop_front());
    end
    prev_stall = resetn ? cpu_stall : 1'b0;
  end

  // One full access: bus accepts after addr_wait cycles of back-pressure,
  // optionally completing in the same cycle, then ls cycles of longstall.
  task automatic run_access(input string name, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input logic [1:0] exp_size,
                            input logic [31:0] exp_addr, input int addr_wait,
                            input bit comb, input int ls, input int exp_stall);
    req_t e;
    int   stalls;
    logic [31:0] exp_data;
    stalls = 0;
    e.wr    = (wen != 4'd0);
    e.size  = exp_size;
    e.addr  = exp_addr;
    e.wdata = wdata;
    exp_req.push_back(e);
    if (!e.wr) last_rd = rdata;
    exp_data = last_rd;
    exp_rd.push_back(exp_data);

    // IDLE: request appears, stall is combinational
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    bus_rdata = e.wr ? 32'hFFFF_FFFF : rdata;
    @(negedge clk); stalls += int'(cpu_stall);

    // ADDR with back-pressure: request fields must hold even if cpu inputs move
    for (int i = 0; i < addr_wait; i++) begin
      @(posedge clk); #1;
      cpu_addr = ~addr; cpu_wdata = ~wdata;
      @(negedge clk);
      stalls += int'(cpu_stall);
      check({name, "_hold_req"},  {31'd0, bus_req}, 32'd1);
      check({name, "_hold_addr"}, bus_addr, exp_addr);
      check({name, "_hold_size"}, {30'd0, bus_size}, {30'd0, exp_size});
      if (e.wr) check({name, "_hold_wdata"}, bus_wdata, wdata);
    end

    // Handshake cycle
    @(posedge clk); #1;
    cpu_addr = addr; cpu_wdata = wdata;
    bus_addr_ok = 1'b1; bus_data_ok = comb;
    @(negedge clk); stalls += int'(cpu_stall);

    // DATA
    if (!comb) begin
      @(posedge clk); #1;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
      @(negedge clk);
      stalls += int'(cpu_stall);
      check({name, "_req_dropped"}, {31'd0, bus_req}, 32'd0);
    end

    // DONE
    @(posedge clk); #1;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h5555_AAAA;
    cpu_longstall = (ls > 0);
    @(negedge clk);
    check({name, "_stall_cycles"}, stalls, exp_stall);
    check({name, "_done_stall"}, {31'd0, cpu_stall}, 32'd0);
    for (int i = 1; i < ls; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_ls_stall"}, {31'd0, cpu_stall}, 32'd0);
      check({name, "_ls_noreq"}, {31'd0, bus_req}, 32'd0);
      check({name, "_ls_rdata"}, cpu_rdata, exp_data);
    end
    if (ls > 0) begin
      @(posedge clk); #1;
      cpu_longstall = 1'b0;
      @(negedge clk);
      check({name, "_ls_release_stall"}, {31'd0, cpu_stall}, 32'd0);
    end

    // Pipeline advances: back to IDLE with no new access
    @(posedge clk); #1;
    cpu_en = 1'b0; cpu_wen = 4'd0;
    @(negedge clk);
    check({name, "_idle_noreq"}, {31'd0, bus_req}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; cpu_en = 1'b0; cpu_wen = 4'd0; cpu_addr = '0; cpu_wdata = '0;
    cpu_longstall = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    last_rd = '0; prev_stall = 1'b0;

    #12;
    check("rst_bus_req",   {31'd0, bus_req},   32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_bus_addr",  bus_addr,  32'd0);
    check("rst_bus_wr",    {31'd0, bus_wr},    32'd0);
    @(posedge clk); #1; resetn = 1'b1;

    //          name     wen      addr          wdata         rdata         size  exp_addr      wait comb ls stall
    run_access("rd",     4'b0000, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 2'd2, 32'h0000_1000, 0, 1'b0, 0, 3);
    run_access("wr_b",   4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0,        2'd0, 32'h0000_2002, 0, 1'b0, 0, 3);
    run_access("rd_bp",  4'b0000, 32'h0000_3004, 32'h0,        32'hCAFE_F00D, 2'd2, 32'h0000_3004, 5, 1'b0, 0, 8);
    run_access("wr_hc",  4'b1100, 32'h0000_4002, 32'h5A5A_0000, 32'h0,        2'd1, 32'h0000_4002, 0, 1'b1, 0, 2);
    run_access("wr_hl",  4'b0011, 32'h0000_4000, 32'h0000_1234, 32'h0,        2'd1, 32'h0000_4000, 0, 1'b0, 0, 3);
    run_access("wr_w",   4'b1111, 32'h0000_4100, 32'h0102_0304, 32'h0,        2'd2, 32'h0000_4100, 1, 1'b0, 0, 4);
    run_access("wr_odd", 4'b0101, 32'h0000_4200, 32'h00FF_00FF, 32'h0,        2'd2, 32'h0000_4200, 0, 1'b0, 0, 3);
    run_access("rd_ls",  4'b0000, 32'h0000_5000, 32'h0,        32'h0BAD_C0DE, 2'd2, 32'h0000_5000, 0, 1'b0, 4, 3);
    run_access("rd_cmb", 4'b0000, 32'h0000_5004, 32'h0,        32'h7777_1111, 2'd2, 32'h0000_5004, 0, 1'b1, 0, 2);
`ifdef DSRAM_BRIDGE_KSEG_MAP_EN
    run_access("kseg1",  4'b0000, 32'hBFAF_F000, 32'h0,        32'h1357_9BDF, 2'd2, 32'h1FAF_F000, 0, 1'b0, 0, 3);
`else
    run_access("kseg1",  4'b0000, 32'hBFAF_F000, 32'h0,        32'h1357_9BDF, 2'd2, 32'hBFAF_F000, 0, 1'b0, 0, 3);
`endif
    run_access("useg",   4'b0000, 32'h0000_0040, 32'h0,        32'h2468_ACE0, 2'd2, 32'h0000_0040, 0, 1'b0, 0, 3);

    // Reset while in DATA: abandon the access, then ignore a stray data_ok.
    begin
      req_t e;
      e.wr = 1'b0; e.size = 2'd2; e.addr = 32'h0000_6000; e.wdata = 32'h0;
      exp_req.push_back(e);
    end
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_wen = 4'd0; cpu_addr = 32'h0000_6000; bus_rdata = 32'h9999_9999;
    @(posedge clk); #1; bus_addr_ok = 1'b1;
    @(posedge clk); #1; bus_addr_ok = 1'b0;
    #1;
    check("rst_mid_data_stall", {31'd0, cpu_stall}, 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_req",   {31'd0, bus_req},   32'd0);
    check("rst_mid_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_mid_rdata", cpu_rdata, 32'd0);
    last_rd = 32'd0;
    @(posedge clk); #1; cpu_en = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    check("stray_dok_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1; bus_data_ok = 1'b0;
    @(negedge clk);
    check("stray_dok_rdata", cpu_rdata, 32'd0);

    run_access("rd_post", 4'b0000, 32'h0000_7000, 32'h0,       32'h1122_3344, 2'd2, 32'h0000_7000, 0, 1'b0, 0, 3);

    repeat (2) @(posedge clk);
    check("req_queue_drained", exp_req.size(), 32'd0);
    check("rd_queue_drained",  exp_rd.size(),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_dsram_bridge
